sram_rr_arbiter: RTL and testbench

Shares one single-port synchronous SRAM between `NUM_REQ` requesters, such as APB bridges, DMA engines and init/scrub engines, using round-robin arbitration. Each requester presents a valid/ready request and receives a one-cycle response pulse. The block sequences the SRAM strobes (CE, OE, byte-WE) and returns the read data. It sits between the requester-side bus adapters and the SRAM macro; the SRAM pin polarities are identical to those of the existing APB-to-SRAM path.

---
 rtl/sram_rr_arbiter_pkg.sv | 11 +
 rtl/sram_rr_arbiter_if.sv | 40 ++++
 rtl/sram_rr_arbiter_rr_pick.sv | 23 ++
 rtl/sram_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_sram_rr_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/sram_rr_arbiter_pkg.sv
// Shared types and limits for the round-robin SRAM arbiter.
package sram_arb_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STROBE  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam int MAX_REQ = 8;
endpackage

// File: rtl/sram_rr_arbiter_if.sv
// Requester-side handshake bus and SRAM pin bundle for the arbiter.
// Handshake: a request moves when REQ_VALID[i] & REQ_READY[i] are both 1 in the same cycle;
// the requester holds its fields stable until then and may drop VALID without side effects.
interface sram_rr_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int NUM_REQ    = 2
);
    localparam int _we_width        = DATA_WIDTH / 8;
    localparam int _sram_addr_width = $clog2(MEM_DEPTH);
    localparam int _id_width        = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                        REQ_VALID;
    logic [NUM_REQ-1:0]                        REQ_READY;
    logic [NUM_REQ-1:0]                        REQ_WRITE;
    logic [NUM_REQ-1:0][_sram_addr_width-1:0]  REQ_ADDR;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]        REQ_WDATA;
    logic [NUM_REQ-1:0][_we_width-1:0]         REQ_BE;
    logic [NUM_REQ-1:0]                        RSP_VALID;
    logic [DATA_WIDTH-1:0]                     RSP_RDATA;
    logic [_id_width-1:0]                      GRANT_ID;
    logic [_sram_addr_width-1:0]               SRAM_ADDR;
    logic                                      SRAM_CE;
    logic [_we_width-1:0]                      SRAM_WE;
    logic                                      SRAM_OE;
    logic [DATA_WIDTH-1:0]                     SRAM_WDATA;
    logic [DATA_WIDTH-1:0]                     SRAM_RDATA;

    modport slave (
        input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, REQ_BE, SRAM_RDATA,
        output REQ_READY, RSP_VALID, RSP_RDATA, GRANT_ID,
        output SRAM_ADDR, SRAM_CE, SRAM_WE, SRAM_OE, SRAM_WDATA
    );

    modport master (
        output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, REQ_BE, SRAM_RDATA,
        input  REQ_READY, RSP_VALID, RSP_RDATA, GRANT_ID,
        input  SRAM_ADDR, SRAM_CE, SRAM_WE, SRAM_OE, SRAM_WDATA
    );
endinterface

// File: rtl/sram_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester after the pointer wins.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    win,
    output logic               any_valid
);
    always_comb begin
        win       = '0;
        any_valid = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            int idx;
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!any_valid && req[idx]) begin
                any_valid = 1'b1;
                win       = ID_W'(idx);
            end
        end
    end
endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM between NUM_REQ requesters.
module sram_rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int NUM_REQ    = 2
) (
    input  logic               CLK,
    input  logic               RST_N,
    sram_rr_arbiter_if.slave   bus,
    output state_t             dbg_state
);
    localparam int _we_width        = DATA_WIDTH / 8;
    localparam int _sram_addr_width = $clog2(MEM_DEPTH);
    localparam int _id_width        = $clog2(NUM_REQ);

    state_t                      state_q, state_d;
    logic [_id_width-1:0]        ptr_q, ptr_d;
    logic [_id_width-1:0]        grant_q, grant_d;
    logic                        write_q, write_d;
    logic [NUM_REQ-1:0]          rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;
    logic [_sram_addr_width-1:0] sram_addr_q, sram_addr_d;
    logic                        ce_q, ce_d;
    logic [_we_width-1:0]        we_q, we_d;
    logic                        oe_q, oe_d;
    logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;

    logic [_id_width-1:0]        win;
    logic                        any_valid;
    logic                        accept;
    logic [NUM_REQ-1:0]          ready;

    rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(_id_width)) u_pick (
        .req       (bus.REQ_VALID),
        .ptr       (ptr_q),
        .win       (win),
        .any_valid (any_valid)
    );

    // Accepting is only possible when the SRAM port is free next cycle; gated by reset too.
    assign accept = RST_N && any_valid && (state_q == IDLE || state_q == RESP);

    always_comb begin
        ready      = '0;
        ready[win] = accept;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        write_d     = write_q;
        rsp_valid_d = '0;
        rdata_d     = rdata_q;
        sram_addr_d = sram_addr_q;
        ce_d        = 1'b1;
        we_d        = '0;
        oe_d        = 1'b1;
        wdata_d     = wdata_q;

        case (state_q)
            IDLE:    state_d = IDLE;
            STROBE:  state_d = CAPTURE;
            CAPTURE: begin
                if (!write_q) rdata_d = bus.SRAM_RDATA;
                rsp_valid_d[grant_q] = 1'b1;
                state_d              = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobe values are registered here so the SRAM pins are clean in the STROBE cycle.
        if (accept) begin
            state_d     = STROBE;
            ptr_d       = win;
            grant_d     = win;
            write_d     = bus.REQ_WRITE[win];
            sram_addr_d = bus.REQ_ADDR[win];
            ce_d        = 1'b0;
            we_d        = bus.REQ_WRITE[win] ? bus.REQ_BE[win] : '0;
            oe_d        = bus.REQ_WRITE[win];
            if (bus.REQ_WRITE[win]) wdata_d = bus.REQ_WDATA[win];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            ptr_q       <= _id_width'(NUM_REQ - 1);
            grant_q     <= '0;
            write_q     <= 1'b0;
            rsp_valid_q <= '0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            ce_q        <= 1'b1;
            we_q        <= '0;
            oe_q        <= 1'b1;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            write_q     <= write_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            ce_q        <= ce_d;
            we_q        <= we_d;
            oe_q        <= oe_d;
            wdata_q     <= wdata_d;
        end
    end

    assign bus.REQ_READY  = ready;
    assign bus.RSP_VALID  = rsp_valid_q;
    assign bus.RSP_RDATA  = rdata_q;
    assign bus.GRANT_ID   = grant_q;
    assign bus.SRAM_ADDR  = sram_addr_q;
    assign bus.SRAM_CE    = ce_q;
    assign bus.SRAM_WE    = we_q;
    assign bus.SRAM_OE    = oe_q;
    assign bus.SRAM_WDATA = wdata_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter with a behavioural single-port SRAM.
module tb_sram_rr_arbiter;
    import sram_arb_pkg::*;

    logic   clk;
    logic   rst_n;
    state_t dbg_state;

    sram_rr_arbiter_if #(.DATA_WIDTH(32), .MEM_DEPTH(1024), .NUM_REQ(2)) bus ();

    sram_rr_arbiter #(.DATA_WIDTH(32), .MEM_DEPTH(1024), .NUM_REQ(2)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: synchronous, read data valid the cycle after the strobe
    logic [31:0] mem [0:1023];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        bus.SRAM_RDATA = 32'h0;
    end
    always @(posedge clk) begin
        if (!bus.SRAM_CE) begin
            for (int b = 0; b < 4; b++)
                if (bus.SRAM_WE[b]) mem[bus.SRAM_ADDR][b*8 +: 8] <= bus.SRAM_WDATA[b*8 +: 8];
            if (!bus.SRAM_OE) bus.SRAM_RDATA <= mem[bus.SRAM_ADDR];
        end
    end

    int tests_run;
    int tests_failed;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},  64'(bus.REQ_READY), 64'h0);
        check({tag, "_rspv"},   64'(bus.RSP_VALID), 64'h0);
        check({tag, "_rdata"},  64'(bus.RSP_RDATA), 64'h0);
        check({tag, "_grant"},  64'(bus.GRANT_ID), 64'h0);
        check({tag, "_addr"},   64'(bus.SRAM_ADDR), 64'h0);
        check({tag, "_ce"},     64'(bus.SRAM_CE), 64'h1);
        check({tag, "_we"},     64'(bus.SRAM_WE), 64'h0);
        check({tag, "_oe"},     64'(bus.SRAM_OE), 64'h1);
        check({tag, "_wdata"},  64'(bus.SRAM_WDATA), 64'h0);
        check({tag, "_state"},  64'(dbg_state), 64'(IDLE));
    endtask

    typedef struct {
        int          id;
        bit          wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];

    task automatic clear_reqs();
        bus.REQ_VALID = '0;
        bus.REQ_WRITE = '0;
        bus.REQ_ADDR  = '0;
        bus.REQ_WDATA = '0;
        bus.REQ_BE    = '0;
    endtask

    task automatic set_req(input int id, input bit wr, input logic [9:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
        bus.REQ_VALID[id] = 1'b1;
        bus.REQ_WRITE[id] = wr;
        bus.REQ_ADDR[id]  = addr;
        bus.REQ_WDATA[id] = wdata;
        bus.REQ_BE[id]    = be;
    endtask

    // Isolated access: accept T0, strobe T1, capture T2, response T3.
    task automatic run_vec(input int n, input vec_t v);
        string t;
        t = $sformatf("v%0d", n);
        @(negedge clk);
        set_req(v.id, v.wr, v.addr, v.wdata, v.be);
        #1;
        check({t, "_ready_t0"}, 64'(bus.REQ_READY), 64'(2'b01 << v.id));
        @(negedge clk);
        bus.REQ_VALID = '0;
        #1;
        check({t, "_ready_t1"}, 64'(bus.REQ_READY), 64'h0);
        check({t, "_ce_t1"},    64'(bus.SRAM_CE), 64'h0);
        check({t, "_addr_t1"},  64'(bus.SRAM_ADDR), 64'(v.addr));
        check({t, "_we_t1"},    64'(bus.SRAM_WE), v.wr ? 64'(v.be) : 64'h0);
        check({t, "_oe_t1"},    64'(bus.SRAM_OE), v.wr ? 64'h1 : 64'h0);
        check({t, "_grant_t1"}, 64'(bus.GRANT_ID), 64'(v.id));
        if (v.wr) check({t, "_wdata_t1"}, 64'(bus.SRAM_WDATA), 64'(v.wdata));
        @(negedge clk);
        check({t, "_ce_t2"},    64'(bus.SRAM_CE), 64'h1);
        check({t, "_oe_t2"},    64'(bus.SRAM_OE), 64'h1);
        check({t, "_we_t2"},    64'(bus.SRAM_WE), 64'h0);
        check({t, "_rspv_t2"},  64'(bus.RSP_VALID), 64'h0);
        @(negedge clk);
        check({t, "_rspv_t3"},  64'(bus.RSP_VALID), 64'(2'b01 << v.id));
        check({t, "_rdata_t3"}, 64'(bus.RSP_RDATA), 64'(v.exp_rdata));
        check({t, "_state_t3"}, 64'(dbg_state), 64'(RESP));
        @(negedge clk);
        check({t, "_rspv_t4"},  64'(bus.RSP_VALID), 64'h0);
        check({t, "_state_t4"}, 64'(dbg_state), 64'(IDLE));
    endtask

    initial begin
        int ce_low;
        int rsp0_cnt;
        int rsp1_cnt;
        logic [1:0]  exp_ready;
        logic [1:0]  last_grant;
        logic [31:0] exp_rd;

        tests_run    = 0;
        tests_failed = 0;

        vecs[0] = '{0, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF, 32'h0};
        vecs[1] = '{1, 1'b0, 10'h005, 32'h0,        4'h0, 32'hDEADBEEF};
        vecs[2] = '{0, 1'b1, 10'h009, 32'h11223344, 4'hF, 32'hDEADBEEF};
        vecs[3] = '{1, 1'b1, 10'h009, 32'h0000AB00, 4'h2, 32'hDEADBEEF};
        vecs[4] = '{0, 1'b0, 10'h009, 32'h0,        4'h0, 32'h1122AB44};
        vecs[5] = '{1, 1'b1, 10'h009, 32'hFFFFFFFF, 4'h0, 32'h1122AB44};
        vecs[6] = '{1, 1'b0, 10'h009, 32'h0,        4'h0, 32'h1122AB44};
        vecs[7] = '{0, 1'b1, 10'h3FF, 32'hA5A55A5A, 4'hF, 32'h1122AB44};
        vecs[8] = '{1, 1'b0, 10'h3FF, 32'h0,        4'h0, 32'hA5A55A5A};
        vecs[9] = '{0, 1'b0, 10'h000, 32'h0,        4'h0, 32'h0};

        // reset
        rst_n = 1'b0;
        clear_reqs();
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;

        // table-driven isolated accesses
        for (int n = 0; n < 10; n++) run_vec(n, vecs[n]);

        // back-to-back: fresh reset so requester 0 wins first, then strict alternation
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 1'b0, 10'h005, 32'h0, 4'h0);
        set_req(1, 1'b0, 10'h3FF, 32'h0, 4'h0);
        last_grant = 2'b00;
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            exp_ready = (cyc % 3 != 0) ? 2'b00 : (((cyc / 3) % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("b2b_ready_c%0d", cyc), 64'(bus.REQ_READY), 64'(exp_ready));
            if (cyc % 3 == 0 && cyc > 0) begin
                exp_rd = (last_grant == 2'b01) ? 32'hDEADBEEF : 32'hA5A55A5A;
                check($sformatf("b2b_rspv_c%0d", cyc), 64'(bus.RSP_VALID), 64'(last_grant));
                check($sformatf("b2b_rdata_c%0d", cyc), 64'(bus.RSP_RDATA), 64'(exp_rd));
            end
            if (cyc % 3 == 0) last_grant = exp_ready;
            @(negedge clk);
        end
        bus.REQ_VALID = '0;
        #1;
        check("b2b_drain_ready", 64'(bus.REQ_READY), 64'h0);
        check("b2b_drain_rspv",  64'(bus.RSP_VALID), 64'(2'b10));
        check("b2b_drain_rdata", 64'(bus.RSP_RDATA), 64'hA5A55A5A);
        @(negedge clk);
        check("b2b_idle", 64'(dbg_state), 64'(IDLE));

        // reset asserted during STROBE drops the access
        @(negedge clk);
        clear_reqs();
        set_req(1, 1'b1, 10'h010, 32'h12345678, 4'hF);
        @(negedge clk);
        check("rst_mid_state", 64'(dbg_state), 64'(STROBE));
        check("rst_mid_ce",    64'(bus.SRAM_CE), 64'h0);
        rst_n = 1'b0;
        set_req(0, 1'b0, 10'h005, 32'h0, 4'h0);
        @(negedge clk);
        check_reset_outputs("rst_mid");
        rst_n = 1'b1;
        #1;
        check("rst_mid_first_win", 64'(bus.REQ_READY), 64'(2'b01));
        @(negedge clk);
        bus.REQ_VALID = '0;
        check("rst_mid_t1_grant", 64'(bus.GRANT_ID), 64'h0);
        check("rst_mid_t1_oe",    64'(bus.SRAM_OE), 64'h0);
        check("rst_mid_t1_rspv",  64'(bus.RSP_VALID), 64'h0);
        @(negedge clk);
        check("rst_mid_t2_rspv",  64'(bus.RSP_VALID), 64'h0);
        @(negedge clk);
        check("rst_mid_t3_rspv",  64'(bus.RSP_VALID), 64'(2'b01));
        check("rst_mid_t3_rdata", 64'(bus.RSP_RDATA), 64'hDEADBEEF);
        @(negedge clk);

        // one-cycle pulse from requester 1 while busy is never accepted
        @(negedge clk);
        clear_reqs();
        set_req(0, 1'b0, 10'h009, 32'h0, 4'h0);
        ce_low   = 0;
        rsp0_cnt = 0;
        rsp1_cnt = 0;
        @(negedge clk);
        bus.REQ_VALID = '0;
        set_req(1, 1'b1, 10'h020, 32'hCAFEF00D, 4'hF);
        #1;
        check("pulse_state", 64'(dbg_state), 64'(STROBE));
        check("pulse_ready", 64'(bus.REQ_READY), 64'h0);
        for (int k = 0; k < 8; k++) begin
            if (!bus.SRAM_CE) ce_low++;
            if (bus.RSP_VALID[0]) rsp0_cnt++;
            if (bus.RSP_VALID[1]) rsp1_cnt++;
            @(negedge clk);
            bus.REQ_VALID = '0;
        end
        check("pulse_ce_low_cycles", 64'(ce_low), 64'd1);
        check("pulse_rsp0",          64'(rsp0_cnt), 64'd1);
        check("pulse_rsp1",          64'(rsp1_cnt), 64'd0);
        check("pulse_rdata",         64'(bus.RSP_RDATA), 64'h1122AB44);
        check("pulse_mem_untouched", 64'(mem[10'h020]), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
